// File: rtl/hub75_pkg.sv
// Shared framebuffer geometry and writer state encoding for the HUB75 display path.
package hub75_pkg;

   localparam int FB_AW    = 14;
   localparam int FB_DW    = 20;
   localparam int FB_WORDS = 16384;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RECV      = 2'd1,
      SWAP_WAIT = 2'd2
   } fbw_state_e;

endpackage

// File: rtl/hub75_bytepack.sv
// Packs a little-endian byte stream into framebuffer words, three bytes per word.
module hub75_bytepack
   import hub75_pkg::*;
(
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic [7:0]       byte_data,
   input  logic             byte_take,
   input  logic             byte_sof,
   output logic [FB_DW-1:0] word,
   output logic             word_valid
);

   logic [1:0] phase_q, phase_d;
   logic [7:0] b0_q, b0_d;
   logic [7:0] b1_q, b1_d;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      phase_d    = phase_q;
      b0_d       = b0_q;
      b1_d       = b1_q;
      word_valid = 1'b0;
      if (byte_take) begin
         if (byte_sof) begin
            b0_d    = byte_data;
            phase_d = 2'd1;
         end else begin
            case (phase_q)
               2'd0: begin
                  b0_d    = byte_data;
                  phase_d = 2'd1;
               end
               2'd1: begin
                  b1_d    = byte_data;
                  phase_d = 2'd2;
               end
               default: begin
                  word_valid = 1'b1;
                  phase_d    = 2'd0;
               end
            endcase
         end
      end
   end

   // The third byte completes the word combinationally; its upper nibble has no home in 20 bits.
   assign word = {byte_data[3:0], b1_q, b0_q};

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= 2'd0;
         b0_q    <= 8'd0;
         b1_q    <= 8'd0;
      end else begin
         phase_q <= phase_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
      end
   end

endmodule

// File: rtl/hub75_fbwriter.sv
// Fills the framebuffer back buffer from a byte stream and swaps buffers on a display frame boundary.
module hub75_fbwriter
   import hub75_pkg::*;
#(
   parameter int WORDS = FB_WORDS,
   parameter int AW    = FB_AW,
   parameter int DW    = FB_DW
) (
   input  logic          sys_clk,
   input  logic          rst_n,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   input  logic          in_sof,
   output logic          in_ready,
   input  logic          frame_boundary,
   output logic [DW-1:0] fb_wdata,
   output logic [AW-1:0] fb_waddr,
   output logic          fb_we,
   output logic          selection,
   output logic          frame_done,
   output logic          resync_err
);

   fbw_state_e    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] fb_wdata_q, fb_wdata_d;
   logic [AW-1:0] fb_waddr_q, fb_waddr_d;
   logic          fb_we_q, fb_we_d;
   logic          selection_q, selection_d;
   logic          frame_done_q, frame_done_d;
   logic          resync_err_q, resync_err_d;

   logic             accept;
   logic             take;
   logic [FB_DW-1:0] pack_word;
   logic             pack_valid;

   assign in_ready = (state_q != SWAP_WAIT);
   assign accept   = in_valid && in_ready;
   // Outside a frame only a start-of-frame byte is worth packing.
   assign take     = accept && ((state_q == RECV) || in_sof);

   hub75_bytepack u_bytepack (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .byte_data  (in_data),
      .byte_take  (take),
      .byte_sof   (in_sof),
      .word       (pack_word),
      .word_valid (pack_valid)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      selection_d  = selection_q;
      frame_done_d = 1'b0;
      resync_err_d = 1'b0;
      fb_we_d      = pack_valid;
      fb_wdata_d   = pack_valid ? pack_word[DW-1:0] : fb_wdata_q;
      fb_waddr_d   = pack_valid ? addr_q : fb_waddr_q;
      case (state_q)
         IDLE: begin
            if (take) begin
               state_d = RECV;
               addr_d  = '0;
            end
         end
         RECV: begin
            if (accept && in_sof) begin
               addr_d       = '0;
               resync_err_d = 1'b1;
            end else if (pack_valid) begin
               if (addr_q == AW'(WORDS - 1)) begin
                  addr_d  = '0;
                  state_d = SWAP_WAIT;
               end else begin
                  addr_d = addr_q + AW'(1);
               end
            end
         end
         SWAP_WAIT: begin
            // The entry cycle still carries the final write, so a boundary there is not honoured.
            if (frame_boundary && !fb_we_q) begin
               selection_d  = ~selection_q;
               frame_done_d = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         fb_wdata_q   <= '0;
         fb_waddr_q   <= '0;
         fb_we_q      <= 1'b0;
         selection_q  <= 1'b0;
         frame_done_q <= 1'b0;
         resync_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         fb_wdata_q   <= fb_wdata_d;
         fb_waddr_q   <= fb_waddr_d;
         fb_we_q      <= fb_we_d;
         selection_q  <= selection_d;
         frame_done_q <= frame_done_d;
         resync_err_q <= resync_err_d;
      end
   end

   assign fb_wdata   = fb_wdata_q;
   assign fb_waddr   = fb_waddr_q;
   assign fb_we      = fb_we_q;
   assign selection  = selection_q;
   assign frame_done = frame_done_q;
   assign resync_err = resync_err_q;

endmodule

// File: tb/tb_hub75_fbwriter.sv
// Directed bench for hub75_fbwriter with a four-word frame.
module tb_hub75_fbwriter;

   logic        sys_clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_sof;
   logic        in_ready;
   logic        frame_boundary;
   logic [19:0] fb_wdata;
   logic [13:0] fb_waddr;
   logic        fb_we;
   logic        selection;
   logic        frame_done;
   logic        resync_err;

   int errors = 0;
   int checks = 0;

   hub75_fbwriter #(.WORDS(4), .AW(14), .DW(20)) dut (
      .sys_clk        (sys_clk),
      .rst_n          (rst_n),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_sof         (in_sof),
      .in_ready       (in_ready),
      .frame_boundary (frame_boundary),
      .fb_wdata       (fb_wdata),
      .fb_waddr       (fb_waddr),
      .fb_we          (fb_we),
      .selection      (selection),
      .frame_done     (frame_done),
      .resync_err     (resync_err)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1);
   end

   // Called at posedge+1; presents one byte across the next edge and returns at posedge+1.
   task automatic send(input logic [7:0] d, input logic sof, input logic fb);
      in_data        = d;
      in_valid       = 1'b1;
      in_sof         = sof;
      frame_boundary = fb;
      @(posedge sys_clk);
      #1;
      in_valid       = 1'b0;
      in_sof         = 1'b0;
      frame_boundary = 1'b0;
   endtask

   task automatic expect_write(input string name, input logic [13:0] a, input logic [19:0] w);
      checks++;
      if (fb_we !== 1'b1 || fb_waddr !== a || fb_wdata !== w) begin
         errors++;
         $display("FAIL %s: we=%b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                  name, fb_we, fb_waddr, fb_wdata, a, w);
      end
   endtask

   task automatic expect_no_write(input string name);
      checks++;
      if (fb_we !== 1'b0) begin
         errors++;
         $display("FAIL %s: fb_we=%b required 0", name, fb_we);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_sof = 1'b0; frame_boundary = 1'b0;
      #3;
      checks++;
      if ({in_ready, fb_we, selection, frame_done, resync_err} !== 5'b10000 ||
          fb_waddr !== 14'd0 || fb_wdata !== 20'd0) begin
         errors++;
         $display("FAIL reset_values: rdy/we/sel/done/rsy=%b addr=%0d data=%h, required 10000 0 00000",
                  {in_ready, fb_we, selection, frame_done, resync_err}, fb_waddr, fb_wdata);
      end
      @(posedge sys_clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_frame;
      logic [19:0] exp_w [4];
      exp_w = '{20'h30201, 20'h60504, 20'h90807, 20'hC0B0A};
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL frame_ready byte %0d: in_ready=%b required 1", i, in_ready);
         end
         send(8'(i + 1), i == 0, 1'b0);
         if (i % 3 == 2) expect_write($sformatf("frame_word%0d", i / 3), 14'(i / 3), exp_w[i / 3]);
         else            expect_no_write($sformatf("frame_gap%0d", i));
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL frame_ready_drop: in_ready=%b required 0", in_ready);
      end
   endtask

   task automatic test_swap;
      for (int i = 0; i < 10; i++) begin
         @(posedge sys_clk);
         #1;
         checks++;
         if (in_ready !== 1'b0 || selection !== 1'b0 || fb_we !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL swap_wait cycle %0d: rdy=%b sel=%b we=%b done=%b required 0 0 0 0",
                     i, in_ready, selection, fb_we, frame_done);
         end
      end
      frame_boundary = 1'b1;
      @(posedge sys_clk);
      #1;
      frame_boundary = 1'b0;
      checks++;
      if (selection !== 1'b1 || frame_done !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL swap_pulse: sel=%b done=%b rdy=%b required 1 1 1", selection, frame_done, in_ready);
      end
      @(posedge sys_clk);
      #1;
      checks++;
      if (frame_done !== 1'b0 || selection !== 1'b1) begin
         errors++;
         $display("FAIL swap_after: done=%b sel=%b required 0 1", frame_done, selection);
      end
   endtask

   task automatic test_idle_drop;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready byte %0d: in_ready=%b required 1", i, in_ready);
         end
         send(8'hA0 + 8'(i), 1'b0, 1'b0);
         expect_no_write($sformatf("idle_drop%0d", i));
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge sys_clk);
         #1;
         expect_no_write($sformatf("idle_quiet%0d", i));
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 6; i++) send(8'h61 + 8'(i), i == 0, 1'b0);
      expect_write("rstmid_word1", 14'd1, 20'h66564);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (fb_we !== 1'b0 || selection !== 1'b0 || in_ready !== 1'b1 || fb_waddr !== 14'd0) begin
         errors++;
         $display("FAIL rstmid_async: we=%b sel=%b rdy=%b addr=%0d required 0 0 1 0",
                  fb_we, selection, in_ready, fb_waddr);
      end
      @(posedge sys_clk);
      #1;
      rst_n = 1'b1;
      send(8'h71, 1'b1, 1'b0);
      send(8'h72, 1'b0, 1'b0);
      send(8'h73, 1'b0, 1'b0);
      expect_write("rstmid_restart", 14'd0, 20'h37271);
   endtask

   task automatic test_resync;
      send(8'h11, 1'b1, 1'b0);
      send(8'h12, 1'b0, 1'b0);
      send(8'h13, 1'b0, 1'b0);
      expect_write("resync_first", 14'd0, 20'h31211);
      send(8'h14, 1'b0, 1'b0);
      expect_no_write("resync_partial");
      send(8'h21, 1'b1, 1'b0);
      checks++;
      if (resync_err !== 1'b1 || fb_we !== 1'b0) begin
         errors++;
         $display("FAIL resync_pulse: resync_err=%b we=%b required 1 0", resync_err, fb_we);
      end
      send(8'h22, 1'b0, 1'b0);
      checks++;
      if (resync_err !== 1'b0 || fb_we !== 1'b0) begin
         errors++;
         $display("FAIL resync_clear: resync_err=%b we=%b required 0 0", resync_err, fb_we);
      end
      send(8'h23, 1'b0, 1'b0);
      expect_write("resync_addr0", 14'd0, 20'h32221);
   endtask

   task automatic test_boundary_same_cycle;
      send(8'h31, 1'b0, 1'b0);
      send(8'h32, 1'b0, 1'b0);
      send(8'h33, 1'b0, 1'b0);
      expect_write("bnd_word1", 14'd1, 20'h33231);
      send(8'h41, 1'b0, 1'b0);
      send(8'h42, 1'b0, 1'b0);
      send(8'h43, 1'b0, 1'b0);
      expect_write("bnd_word2", 14'd2, 20'h34241);
      send(8'hAB, 1'b0, 1'b0);
      send(8'hCD, 1'b0, 1'b0);
      send(8'hEF, 1'b0, 1'b1);
      expect_write("bnd_word3", 14'd3, 20'hFCDAB);
      checks++;
      if (selection !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bnd_early_pulse: sel=%b done=%b rdy=%b required 0 0 0", selection, frame_done, in_ready);
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge sys_clk);
         #1;
         checks++;
         if (selection !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL bnd_hold %0d: sel=%b done=%b required 0 0", i, selection, frame_done);
         end
      end
      frame_boundary = 1'b1;
      @(posedge sys_clk);
      #1;
      frame_boundary = 1'b0;
      checks++;
      if (selection !== 1'b1 || frame_done !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bnd_second_pulse: sel=%b done=%b rdy=%b required 1 1 1", selection, frame_done, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_swap();
      test_idle_drop();
      test_reset_mid();
      test_resync();
      test_boundary_same_cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hub75_fbwriter.md
Name: hub75_fbwriter

Overview:
- Write-side counterpart to the HUB75 display path: receives a byte stream of pixel data and fills the framebuffer write port.
- Packs bytes into 20-bit framebuffer words and writes them at sequential addresses.
- Flips the double-buffer `selection` once a full frame is written, but only at a display frame boundary, so the scan-out never sees a partial frame.
- Sits between an upstream byte source (SPI/USB bridge) and the framebuffer write port. The read port stays owned by the fetch/shift path.

Parameters:
- `WORDS`, default 16384: framebuffer words per frame. Legal range 2..16384.
- `AW`, default 14: framebuffer address width.
- `DW`, default 20: framebuffer data width. Fixed at 20; 3 bytes per word.

Ports:
- `sys_clk`  in  1  system clock. Also the framebuffer `wclk`, which the top level connects to `sys_clk`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_sof`  in  1  qualifies `in_data` as the first byte of a frame; sampled only with `in_valid`.
- `in_ready`  out  1  byte is accepted when `in_valid && in_ready`.
- `frame_boundary`  in  1  one-cycle pulse from the main FSM after the last row/bit of a displayed frame.
- `fb_wdata`  out  20  framebuffer write data.
- `fb_waddr`  out  14  framebuffer write address.
- `fb_we`  out  1  framebuffer write enable.
- `selection`  out  1  front/back buffer select, driven to the framebuffer.
- `frame_done`  out  1  one-cycle pulse when `selection` toggles.
- `resync_err`  out  1  one-cycle pulse when an `in_sof` aborts a partial frame.

Behaviour:
- Reset (async assert, sync release): state=IDLE; `in_ready`=1; `fb_we`=0; `fb_waddr`=0; `fb_wdata`=0; `selection`=0; `frame_done`=0; `resync_err`=0; byte phase=0; address counter=0.
- States:
  - IDLE: `in_ready`=1. Bytes without `in_sof` are accepted and dropped. An accepted `in_sof` byte is stored as byte 0, phase=1, next state=RECV.
  - RECV: `in_ready`=1. Each accepted byte is stored at the current phase (0,1,2), little-endian. On the byte that completes phase 2, the 24-bit word is formed.
    - Next cycle: `fb_we`=1, `fb_wdata`=word[19:0] (bits 23:20 discarded), `fb_waddr`=addr.
    - Latency is one cycle from acceptance of the third byte. Back-to-back words are allowed: one write per 3 accepted bytes, no bubbles required.
    - If the completed word has addr=`WORDS`-1, next state=SWAP_WAIT and the address counter wraps to 0. Otherwise addr+1.
  - SWAP_WAIT: `in_ready`=0. On `frame_boundary`=1: toggle `selection`, pulse `frame_done`, go to IDLE.
    - If `frame_boundary` is asserted in the same cycle SWAP_WAIT is entered, the swap waits for the next pulse; the boundary must be seen while already in SWAP_WAIT.
- Mid-frame `in_sof` in RECV (any phase, any addr): discard the partial word, addr=0, store the byte as byte 0, phase=1, pulse `resync_err`, stay in RECV. A write already scheduled for this cycle still completes.
- `in_sof` ignored in SWAP_WAIT, since no byte is accepted there.
- `frame_boundary` outside SWAP_WAIT is ignored.
- `fb_we` is high for exactly one cycle per word. `fb_waddr`/`fb_wdata` hold their last values when `fb_we`=0.
- Writes always target the back buffer. The framebuffer maps the write port to `!selection`, so `selection` must not change while `fb_we`=1.
- Reset asserted mid-frame: everything returns to reset values, including `selection`=0. The partial frame is abandoned.

Decomposition:
- Shared package `hub75_pkg`: `FB_AW`=14, `FB_DW`=20, `FB_WORDS`=16384, and the state encoding (IDLE=2'd0, RECV=2'd1, SWAP_WAIT=2'd2).
- One natural sub-module, `hub75_bytepack`: phase counter plus 24-bit assembly register. Has an sof/clear input and emits word + `word_valid`.
- Address counter and state machine stay in `hub75_fbwriter`.

Test Plan:
- `WORDS`=4; `in_sof` on byte 0x01, then bytes 0x02..0x0C (12 bytes total, continuous valid).
  - Required: `fb_we` pulses at addr 0,1,2,3 with wdata 0x30201, 0x60504, 0x90807, 0xC0B0A.
  - Each pulse one cycle after the third byte of its word.
  - `in_ready` drops after the 12th byte.
- Continue the previous case: hold `frame_boundary`=0 for 10 cycles, then pulse.
  - Required: `selection` 0→1 and `frame_done` in the cycle after the pulse.
  - `in_ready` low until then; returns to 1 in IDLE.
- 5 bytes with no `in_sof` while IDLE.
  - Required: all accepted, no `fb_we`, state stays IDLE.
- `WORDS`=4; sof + 4 bytes (1 word + 1 partial), then a new `in_sof` byte.
  - Required: `resync_err` pulse; next write lands at addr 0.
  - Partial byte never written; first word of the old frame remains written at addr 0 until overwritten.
- `frame_boundary` asserted in the same cycle the last word completes.
  - Required: no swap on that pulse; swap on the next pulse.
- Drop `rst_n` while in RECV at addr 2.
  - Required: immediately `fb_we`=0, `selection`=0, `in_ready`=1.
  - After release, a new frame writes from addr 0.
